// File: rtl/keypad_matrix_model.sv
// Passive 4x4 keypad matrix responder: models one pressed key with LFSR contact bounce and
// returns row sense combinationally from the scanner's column drive.
module keypad_matrix_model #(
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_press,
    input  logic       cmd_release,
    input  logic [3:0] key_code,
    input  logic [3:0] c,
    output logic [3:0] r,
    output logic       busy,
    output logic       held,
    output logic       contact,
    output logic [7:0] press_count
);

    localparam int unsigned CNT_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BOUNCE_DN = 2'd1,
        S_HELD      = 2'd2,
        S_BOUNCE_UP = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       key, key_nx;
    logic             contact_nx;
    logic [7:0]       press_count_nx;
    logic [7:0]       lfsr;
    logic             lfsr_fb;

    // x^8 + x^6 + x^5 + x^4 + 1
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            key         <= 4'h0;
            contact     <= 1'b0;
            press_count <= 8'h00;
            lfsr        <= SEED;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            key         <= key_nx;
            contact     <= contact_nx;
            press_count <= press_count_nx;
            lfsr        <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        key_nx         = key;
        contact_nx     = contact;
        press_count_nx = press_count;
        case (state)
            S_IDLE: begin
                if (cmd_press) begin
                    key_nx = key_code;
                    if (BOUNCE_CYCLES > 0) begin
                        cnt_nx   = CNT_LOAD;
                        state_nx = S_BOUNCE_DN;
                    end else begin
                        contact_nx = 1'b1;
                        state_nx   = S_HELD;
                    end
                end
            end
            S_BOUNCE_DN: begin
                if (cnt == '0) begin
                    contact_nx = 1'b1;
                    state_nx   = S_HELD;
                end else begin
                    contact_nx = lfsr[0];
                    cnt_nx     = cnt - CNT_W'(1);
                end
            end
            S_HELD: begin
                contact_nx = 1'b1;
                if (cmd_release) begin
                    if (BOUNCE_CYCLES > 0) begin
                        cnt_nx   = CNT_LOAD;
                        state_nx = S_BOUNCE_UP;
                    end else begin
                        contact_nx     = 1'b0;
                        press_count_nx = press_count + 8'd1;
                        state_nx       = S_IDLE;
                    end
                end
            end
            S_BOUNCE_UP: begin
                if (cnt == '0) begin
                    contact_nx     = 1'b0;
                    press_count_nx = press_count + 8'd1;
                    state_nx       = S_IDLE;
                end else begin
                    contact_nx = lfsr[0];
                    cnt_nx     = cnt - CNT_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Matrix behaviour: only the latched key's row follows its column, zero latency.
    always_comb begin
        busy = (state == S_BOUNCE_DN) || (state == S_BOUNCE_UP);
        held = (state == S_HELD);
        r    = 4'h0;
        if (contact) begin
            r[key[3:2]] = c[key[1:0]];
        end
    end

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Scoreboard bench for keypad_matrix_model: two instances (bouncing and clean edges) checked
// every cycle against a behavioural matrix/contact model, plus directed anchor checks.
module tb_keypad_matrix_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_press [2];
    logic       cmd_release [2];
    logic [3:0] key_code [2];
    logic [3:0] c [2];
    logic [3:0] r [2];
    logic       busy [2];
    logic       held [2];
    logic       contact [2];
    logic [7:0] press_count [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_matrix_model #(.BOUNCE_CYCLES(8), .LFSR_SEED(8'hA5)) u_dut8 (
        .clk(clk), .reset(rst), .cmd_press(cmd_press[0]), .cmd_release(cmd_release[0]),
        .key_code(key_code[0]), .c(c[0]), .r(r[0]), .busy(busy[0]), .held(held[0]),
        .contact(contact[0]), .press_count(press_count[0])
    );

    keypad_matrix_model #(.BOUNCE_CYCLES(0), .LFSR_SEED(8'h00)) u_dut0 (
        .clk(clk), .reset(rst), .cmd_press(cmd_press[1]), .cmd_release(cmd_release[1]),
        .key_code(key_code[1]), .c(c[1]), .r(r[1]), .busy(busy[1]), .held(held[1]),
        .contact(contact[1]), .press_count(press_count[1])
    );

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_DN, M_HELD, M_UP} mph_t;
    typedef struct packed {
        logic [3:0] r;
        logic       busy;
        logic       held;
        logic       contact;
        logic [7:0] cnt;
    } obs_t;

    mph_t       ph [2];
    int         left [2];
    logic [3:0] mkey [2];
    logic       mcon [2];
    int         mcnt [2];
    logic [7:0] mlfsr [2];
    logic       lbit;
    obs_t       expq [$];

    function automatic int bc(input int i);
        return (i == 0) ? 8 : 0;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic obs_t exp_of(input int i);
        obs_t       o;
        logic [3:0] k;
        logic [3:0] cc;
        k         = mkey[i];
        cc        = c[i];
        o.r       = (mcon[i] && cc[k[1:0]]) ? 4'(1 << k[3:2]) : 4'h0;
        o.busy    = (ph[i] == M_DN) || (ph[i] == M_UP);
        o.held    = (ph[i] == M_HELD);
        o.contact = mcon[i];
        o.cnt     = 8'(mcnt[i]);
        return o;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    ph[i] = M_IDLE; left[i] = 0; mkey[i] = 4'h0; mcon[i] = 1'b0; mcnt[i] = 0;
                    mlfsr[i] = (i == 0) ? 8'hA5 : 8'h01;
                end else begin
                    lbit     = mlfsr[i][0];
                    mlfsr[i] = lfsr_step(mlfsr[i]);
                    case (ph[i])
                        M_IDLE: if (cmd_press[i]) begin
                            mkey[i] = key_code[i];
                            if (bc(i) == 0) begin mcon[i] = 1'b1; ph[i] = M_HELD; end
                            else begin left[i] = bc(i); ph[i] = M_DN; end
                        end
                        M_DN: begin
                            left[i]--;
                            if (left[i] == 0) begin mcon[i] = 1'b1; ph[i] = M_HELD; end
                            else mcon[i] = lbit;
                        end
                        M_HELD: if (cmd_release[i]) begin
                            if (bc(i) == 0) begin mcon[i] = 1'b0; ph[i] = M_IDLE; mcnt[i]++; end
                            else begin left[i] = bc(i); ph[i] = M_UP; end
                        end
                        M_UP: begin
                            left[i]--;
                            if (left[i] == 0) begin mcon[i] = 1'b0; ph[i] = M_IDLE; mcnt[i]++; end
                            else mcon[i] = lbit;
                        end
                        default: ph[i] = M_IDLE;
                    endcase
                end
                expq.push_back(exp_of(i));
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL obs[%0d] t=%0t scoreboard empty", i, $time);
                end else begin
                    e = expq.pop_front();
                    a.r = r[i]; a.busy = busy[i]; a.held = held[i];
                    a.contact = contact[i]; a.cnt = press_count[i];
                    if (a !== e) begin
                        failures++;
                        $display("FAIL obs[%0d] t=%0t got r=%h busy=%b held=%b contact=%b cnt=%0d want r=%h busy=%b held=%b contact=%b cnt=%0d",
                                 i, $time, a.r, a.busy, a.held, a.contact, a.cnt,
                                 e.r, e.busy, e.held, e.contact, e.cnt);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cmd_press[i]   = 1'b0;
            cmd_release[i] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    task automatic wait_ph(input int i, input mph_t want, input int bound, input string name);
        int n = 0;
        while (ph[i] != want && n < bound) begin
            tick();
            n++;
        end
        if (ph[i] != want) begin
            checks++;
            failures++;
            $display("FAIL %s timeout after %0d cycles", name, n);
        end
    endtask

    task automatic settle();
        int n = 0;
        while ((ph[0] != M_IDLE || ph[1] != M_IDLE) && n < 100) begin
            for (int i = 0; i < 2; i++) if (ph[i] == M_HELD) cmd_release[i] = 1'b1;
            tick();
            n++;
        end
        if (ph[0] != M_IDLE || ph[1] != M_IDLE) begin
            checks++;
            failures++;
            $display("FAIL settle timeout");
        end
    endtask

    function automatic logic [3:0] rand_c();
        case ($urandom_range(0, 2))
            0:       return 4'(1 << $urandom_range(0, 3));
            1:       return 4'($urandom);
            default: return 4'h0;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_press[i] = 1'b0; cmd_release[i] = 1'b0; key_code[i] = 4'h0; c[i] = 4'hF;
        end

        // reset with all columns driven
        repeat (3) tick();
        #1;
        chk("rst_r0", r[0], 0); chk("rst_r1", r[1], 0);
        chk("rst_busy", busy[0], 0); chk("rst_held", held[0], 0); chk("rst_cnt", press_count[0], 0);
        rst = 1'b0;
        repeat (10) tick();
        #1;
        chk("post_rst_r", r[0], 0); chk("post_rst_cnt", press_count[0], 0);

        // bounced press of key 4'b1101
        key_code[0] = 4'b1101; cmd_press[0] = 1'b1;
        tick();
        n = 0;
        while (busy[0] && n < 20) begin c[0] = rand_c(); tick(); n++; end
        chk("press_busy_len", n, 8);
        chk("press_held", held[0], 1); chk("press_contact", contact[0], 1);
        c[0] = 4'b0010; #1 chk("held_r_col1", r[0], 4'b1000);
        c[0] = 4'b0100; #1 chk("held_r_col2", r[0], 0);
        c[0] = 4'b0000; #1 chk("held_r_none", r[0], 0);

        // bounced release
        cmd_release[0] = 1'b1;
        tick();
        n = 0;
        while (busy[0] && n < 20) begin c[0] = rand_c(); tick(); n++; end
        chk("release_busy_len", n, 8);
        chk("release_held", held[0], 0); chk("release_contact", contact[0], 0);
        chk("release_cnt", press_count[0], 1);
        c[0] = 4'hF; #1 chk("idle_r", r[0], 0);

        // press during bounce is dropped
        key_code[0] = 4'h5; cmd_press[0] = 1'b1;
        tick();
        key_code[0] = 4'h0; cmd_press[0] = 1'b1;
        tick();
        wait_ph(0, M_HELD, 20, "t4_held");
        chk("t4_held", held[0], 1);
        c[0] = 4'b0010; #1 chk("t4_r_key5", r[0], 4'b0010);
        cmd_release[0] = 1'b1;
        tick();
        wait_ph(0, M_IDLE, 20, "t4_idle");

        // clean edges
        key_code[1] = 4'h0; cmd_press[1] = 1'b1;
        tick();
        chk("clean_held", held[1], 1); chk("clean_busy", busy[1], 0);
        c[1] = 4'b0001; #1 chk("clean_r", r[1], 4'b0001);
        cmd_release[1] = 1'b1;
        tick();
        chk("clean_idle", held[1], 0); chk("clean_cnt", press_count[1], 1);

        // random traffic on both instances
        repeat (1500) begin
            for (int i = 0; i < 2; i++) begin
                cmd_press[i]   = ($urandom_range(0, 3) == 0);
                cmd_release[i] = ($urandom_range(0, 3) == 0);
                key_code[i]    = 4'($urandom);
                c[i]           = rand_c();
            end
            tick();
        end
        settle();

        // async reset in the middle of a release bounce
        key_code[0] = 4'($urandom); cmd_press[0] = 1'b1;
        tick();
        wait_ph(0, M_HELD, 20, "t6_held");
        cmd_release[0] = 1'b1;
        tick();
        tick();
        c[0] = 4'hF; c[1] = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_r0", r[0], 0); chk("async_rst_busy", busy[0], 0);
        chk("async_rst_cnt", press_count[0], 0); chk("async_rst_r1", r[1], 0);
        tick();
        rst = 1'b0;

        // 256 full cycles wrap the counter on both instances
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 2; i++) begin
                key_code[i] = 4'($urandom); cmd_press[i] = 1'b1; c[i] = rand_c();
            end
            tick();
            wait_ph(0, M_HELD, 20, "wrap_held");
            cmd_release[0] = 1'b1; cmd_release[1] = 1'b1;
            tick();
            wait_ph(0, M_IDLE, 20, "wrap_idle");
            if (k == 254) begin
                chk("cnt_255_a", press_count[0], 255); chk("cnt_255_b", press_count[1], 255);
            end
        end
        chk("cnt_wrap_a", press_count[0], 0); chk("cnt_wrap_b", press_count[1], 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
